// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and fault-cause encoding for the instruction fetch path
package rv_pkg;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    typedef enum logic [1:0] {FAULT_NONE, FAULT_MISALIGNED, FAULT_RANGE} fault_cause_e;
    function automatic fault_cause_e fault_cause(input logic misaligned, input logic out_of_range);
        return misaligned ? FAULT_MISALIGNED : out_of_range ? FAULT_RANGE : FAULT_NONE;
    endfunction
endpackage

// File: rtl/imem_addr_check.sv
// imem_addr_check: word alignment and in-range check for a byte address
module imem_addr_check #(
    parameter int ADDR_W      = 64,
    parameter int DEPTH_BYTES = 256
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              aligned_o,
    output logic              in_range_o
);
    // One extra bit so addresses near the top of the space cannot wrap into range
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH_BYTES);
    assign aligned_o  = addr_i[1:0] == 2'b00;
    assign in_range_o = ({1'b0, addr_i} + (ADDR_W+1)'(3)) < LIMIT;
endmodule

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: byte-addressed instruction memory with registered fetch output and run-time word loads
module instr_mem_sync import rv_pkg::*; #(
    parameter int          DEPTH_BYTES = 256,
    parameter int          ADDR_W      = 64,
    parameter logic [31:0] NOP_WORD    = rv_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [31:0]       Instruction,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    output logic              fault_misaligned,
    output logic              fault_range,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_err
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    logic [7:0]        mem_q [DEPTH_BYTES];
    logic [31:0]       ins_q, ins_d, rd_word;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d, mis_q, mis_d, rng_q, rng_d, lerr_q;
    logic              f_aligned, f_in_range, l_aligned, l_in_range, f_ok, l_ok, accept;
    logic [IDX_W-1:0]  fa, la;

    imem_addr_check #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH_BYTES)) u_fetch_chk (
        .addr_i(fetch_addr), .aligned_o(f_aligned), .in_range_o(f_in_range));
    imem_addr_check #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH_BYTES)) u_load_chk (
        .addr_i(load_addr), .aligned_o(l_aligned), .in_range_o(l_in_range));

    assign f_ok        = f_aligned && f_in_range;
    assign l_ok        = l_aligned && l_in_range;
    assign fetch_ready = !stall && !load_we;
    assign accept      = fetch_req && fetch_ready;
    assign fa          = fetch_addr[IDX_W-1:0];
    assign la          = load_addr[IDX_W-1:0];
    assign rd_word     = {mem_q[fa + IDX_W'(3)], mem_q[fa + IDX_W'(2)], mem_q[fa + IDX_W'(1)], mem_q[fa]};

    // Storage is deliberately not reset so programs survive a core reset
    always_ff @(posedge clk) begin
        if (!reset && load_we && l_ok)
            for (int k = 0; k < 4; k++) mem_q[la + IDX_W'(k)] <= load_data[8*k +: 8];
    end

    always_comb begin
        ins_d   = ins_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        rng_d   = rng_q;
        if (flush) begin
            ins_d   = NOP_WORD;
            valid_d = 1'b0;
            mis_d   = 1'b0;
            rng_d   = 1'b0;
        end else if (!stall) begin
            pc_d    = accept ? fetch_addr : pc_q;
            ins_d   = (accept && f_ok) ? rd_word : NOP_WORD;
            valid_d = accept && f_ok;
            mis_d   = accept && !f_aligned;
            rng_d   = accept && !f_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ins_q   <= NOP_WORD;
            pc_q    <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            ins_q   <= ins_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            rng_q   <= rng_d;
            lerr_q  <= load_we && !l_ok;
        end
    end

    assign Instruction      = ins_q;
    assign inst_pc          = pc_q;
    assign inst_valid       = valid_q;
    assign fault_misaligned = mis_q;
    assign fault_range      = rng_q;
    assign load_err         = lerr_q;
endmodule
